// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: sequential signed-decimal / hex converter feeding an atomically committed glyph buffer,
// scanned onto a one-hot-low digit bus. Define FND_BLINK_EN for per-digit blinking via blink_mask.
module fnd_scan_driver #(
    parameter int DIGITS       = 6,
    parameter int DATA_W       = 32,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              fnd_clk,
    input  logic              rst,
    input  logic              load,
    input  logic              mode,
    input  logic [DATA_W-1:0] value,
`ifdef FND_BLINK_EN
    input  logic [DIGITS-1:0] blink_mask,
`endif
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] fnd_s,
    output logic [7:0]        fnd_d
);
    localparam int BCD_N = (DATA_W + 2) / 3;
    localparam int NW    = BCD_N > DIGITS ? BCD_N : DIGITS;
    localparam int CW    = $clog2(DATA_W + 1);
    localparam int PW    = $clog2(SCAN_DIV);
    localparam int IW    = $clog2(DIGITS);
    localparam logic [1:0] IDLE = 2'd0, CONV_DEC = 2'd1, CONV_HEX = 2'd2, COMMIT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              mode_q, mode_d, neg_q, neg_d, ovf_q, ovf_d, err, hi;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [4*NW-1:0]   bcd_q, bcd_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     msd, idx_q, idx_d;
    logic [PW-1:0]     psc_q, psc_d;
    logic [7:0]        buf_q [DIGITS];
    logic [7:0]        buf_d [DIGITS];
    logic [7:0]        gly   [DIGITS];
    logic [DIGITS-1:0] fnd_s_q, fnd_s_d;
    logic [7:0]        fnd_d_q, fnd_d_d;
    logic              psc_wrap;

    function automatic logic [7:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h67;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
    endfunction

    // Glyph encoding of the finished conversion; only consumed in COMMIT
    always_comb begin
        msd = '0;
        hi  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                if (i < DIGITS) msd = IW'(i);
                else hi = 1'b1;
            end
        end
        err = hi || (mode_q ? |sh_q : neg_q && msd == IW'(DIGITS - 1));
        for (int i = 0; i < DIGITS; i++) begin
            gly[i] = err ? (i < 2 ? 8'h50 : i == 2 ? 8'h79 : 8'h00) :
                     IW'(i) <= msd ? seg(bcd_q[4*i +: 4]) :
                     (neg_q && IW'(i) == msd + 1'b1) ? 8'h40 : 8'h00;
        end
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NW; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        state_d = state_q;
        mode_d  = mode_q;
        neg_d   = neg_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (load) begin
                state_d = mode ? CONV_HEX : CONV_DEC;
                mode_d  = mode;
                neg_d   = !mode && value[DATA_W-1];
                sh_d    = (!mode && value[DATA_W-1]) ? -value : value;
                bcd_d   = '0;
                cnt_d   = '0;
            end
            CONV_DEC: begin
                sh_d    = sh_q << 1;
                bcd_d   = {adj[4*NW-2:0], sh_q[DATA_W-1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(DATA_W - 1) ? COMMIT : CONV_DEC;
            end
            CONV_HEX: begin
                sh_d    = sh_q >> 4;
                bcd_d   = (bcd_q >> 4) | ((4*NW)'(sh_q[3:0]) << (4 * (DIGITS - 1)));
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(DIGITS - 1) ? COMMIT : CONV_HEX;
            end
            default: begin
                buf_d   = gly;
                ovf_d   = err;
                state_d = IDLE;
            end
        endcase
    end

    assign psc_wrap = psc_q == PW'(SCAN_DIV - 1);
    assign psc_d    = psc_wrap ? '0 : psc_q + 1'b1;
    assign idx_d    = psc_wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    assign fnd_s_d  = psc_d == '0 ? '1 : ~(DIGITS'(1) << idx_d);

`ifdef FND_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frm_q, frm_d;
    logic          ph_q, ph_d, frm_wrap;
    assign frm_wrap = psc_wrap && idx_q == IW'(DIGITS - 1) && frm_q == FW'(BLINK_FRAMES - 1);
    assign frm_d    = (psc_wrap && idx_q == IW'(DIGITS - 1)) ? (frm_wrap ? '0 : frm_q + 1'b1) : frm_q;
    assign ph_d     = ph_q ^ frm_wrap;
    assign fnd_d_d  = (!ph_d && blink_mask[idx_d]) ? 8'h00 : buf_q[idx_d];
    always_ff @(posedge fnd_clk) begin
        frm_q <= !rst ? '0 : frm_d;
        ph_q  <= !rst ? 1'b1 : ph_d;
    end
`else
    assign fnd_d_d = buf_q[idx_d];
`endif

    always_ff @(posedge fnd_clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            neg_q   <= 1'b0;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '{default: 8'h40};
            ovf_q   <= 1'b0;
            psc_q   <= '0;
            idx_q   <= '0;
            fnd_s_q <= '1;
            fnd_d_q <= 8'h00;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            psc_q   <= psc_d;
            idx_q   <= idx_d;
            fnd_s_q <= fnd_s_d;
            fnd_d_q <= fnd_d_d;
        end
    end

    assign busy     = state_q != IDLE;
    assign overflow = ovf_q;
    assign fnd_s    = fnd_s_q;
    assign fnd_d    = fnd_d_q;
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed checks of conversion, glyph rules, overflow, handshake and scan timing
// with DIGITS=6, DATA_W=32, SCAN_DIV=4; the blink scenario runs only when FND_BLINK_EN is defined.
module tb_fnd_scan_driver;
    logic        fnd_clk = 1'b0;
    logic        rst     = 1'b0;
    logic        load    = 1'b0;
    logic        mode    = 1'b0;
    logic [31:0] value   = '0;
    logic        busy, overflow;
    logic [5:0]  fnd_s;
    logic [7:0]  fnd_d;
`ifdef FND_BLINK_EN
    logic [5:0]  blink_mask = '0;
`endif
    int          n_chk = 0, n_fail = 0, bcnt;
    logic [47:0] frame;

    always #5 fnd_clk = ~fnd_clk;

    fnd_scan_driver #(.DIGITS(6), .DATA_W(32), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .fnd_clk(fnd_clk), .rst(rst), .load(load), .mode(mode), .value(value),
`ifdef FND_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .busy(busy), .overflow(overflow), .fnd_s(fnd_s), .fnd_d(fnd_d)
    );

    // Collects the last glyph seen on each digit over slightly more than one frame
    task automatic capture_frame();
        frame = 'x;
        repeat (2) @(negedge fnd_clk);
        repeat (26) begin
            @(negedge fnd_clk);
            for (int i = 0; i < 6; i++)
                if (fnd_s == ~(6'd1 << i)) frame[8*i +: 8] = fnd_d;
        end
    endtask

    task automatic do_load(input logic m, input logic [31:0] v);
        @(negedge fnd_clk);
        load = 1'b1; mode = m; value = v;
        @(negedge fnd_clk);
        load = 1'b0;
        bcnt = 0;
        while (busy && bcnt < 100) begin
            bcnt++;
            @(negedge fnd_clk);
        end
        capture_frame();
    endtask

    task automatic test_reset();
        logic [5:0] exp_s [8];
        exp_s = '{6'h3F, 6'h3E, 6'h3E, 6'h3E, 6'h3F, 6'h3D, 6'h3D, 6'h3D};
        rst = 1'b0; load = 1'b1; value = 32'd5;
        repeat (3) @(negedge fnd_clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_chk++; if (fnd_s !== 6'h3F) begin n_fail++; $display("FAIL rst_fnd_s got %h want 3f", fnd_s); end
        n_chk++; if (fnd_d !== 8'h00) begin n_fail++; $display("FAIL rst_fnd_d got %h want 00", fnd_d); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow); end
        rst = 1'b1; load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (fnd_s !== exp_s[k]) begin n_fail++; $display("FAIL scan_seq[%0d] got %b want %b", k, fnd_s, exp_s[k]); end
            @(negedge fnd_clk);
        end
        capture_frame();
        n_chk++; if (frame !== 48'h404040404040) begin n_fail++; $display("FAIL rst_glyphs got %h want 404040404040", frame); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_after got %b want 0", busy); end
    endtask

    task automatic test_decimal();
        do_load(1'b0, 32'd123);
        n_chk++; if (bcnt !== 33) begin n_fail++; $display("FAIL dec_busy_len got %0d want 33", bcnt); end
        n_chk++; if (frame !== 48'h000000065B4F) begin n_fail++; $display("FAIL dec_123 got %h want 000000065b4f", frame); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_123_ovf got %b want 0", overflow); end
        do_load(1'b0, -32'sd45);
        n_chk++; if (frame !== 48'h00000040666D) begin n_fail++; $display("FAIL dec_m45 got %h want 00000040666d", frame); end
        do_load(1'b0, 32'h80000000);
        n_chk++; if (frame !== 48'h000000795050) begin n_fail++; $display("FAIL dec_min_err got %h want 000000795050", frame); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL dec_min_ovf got %b want 1", overflow); end
        do_load(1'b0, 32'd999999);
        n_chk++; if (frame !== 48'h676767676767) begin n_fail++; $display("FAIL dec_999999 got %h want 676767676767", frame); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_999999_ovf got %b want 0", overflow); end
        do_load(1'b0, 32'd0);
        n_chk++; if (frame !== 48'h00000000003F) begin n_fail++; $display("FAIL dec_zero got %h want 00000000003f", frame); end
        do_load(1'b0, -32'sd99999);
        n_chk++; if (frame !== 48'h406767676767) begin n_fail++; $display("FAIL dec_m99999 got %h want 406767676767", frame); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_m99999_ovf got %b want 0", overflow); end
        do_load(1'b0, -32'sd100000);
        n_chk++; if (frame !== 48'h000000795050) begin n_fail++; $display("FAIL dec_sign_err got %h want 000000795050", frame); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL dec_sign_ovf got %b want 1", overflow); end
        do_load(1'b0, 32'd1000000);
        n_chk++; if (frame !== 48'h000000795050) begin n_fail++; $display("FAIL dec_7dig_err got %h want 000000795050", frame); end
    endtask

    task automatic test_hex();
        do_load(1'b1, 32'h0000BEEF);
        n_chk++; if (bcnt !== 7) begin n_fail++; $display("FAIL hex_busy_len got %0d want 7", bcnt); end
        n_chk++; if (frame !== 48'h00007C797971) begin n_fail++; $display("FAIL hex_beef got %h want 00007c797971", frame); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL hex_beef_ovf got %b want 0", overflow); end
        do_load(1'b1, 32'h00FFFFFF);
        n_chk++; if (frame !== 48'h717171717171) begin n_fail++; $display("FAIL hex_ffffff got %h want 717171717171", frame); end
        do_load(1'b1, 32'h01000000);
        n_chk++; if (frame !== 48'h000000795050) begin n_fail++; $display("FAIL hex_err got %h want 000000795050", frame); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL hex_err_ovf got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid();
        @(negedge fnd_clk);
        load = 1'b1; mode = 1'b0; value = 32'd888;
        @(negedge fnd_clk);
        load = 1'b0;
        repeat (9) @(negedge fnd_clk);
        rst = 1'b0;
        @(negedge fnd_clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got %b want 0", overflow); end
        n_chk++; if (fnd_s !== 6'h3F) begin n_fail++; $display("FAIL mid_rst_fnd_s got %h want 3f", fnd_s); end
        rst = 1'b1;
        capture_frame();
        n_chk++; if (frame !== 48'h404040404040) begin n_fail++; $display("FAIL mid_rst_glyphs got %h want 404040404040", frame); end
    endtask

    task automatic test_busy_ignore();
        @(negedge fnd_clk);
        load = 1'b1; mode = 1'b0; value = 32'd7;
        @(negedge fnd_clk);
        bcnt = 0;
        while (busy && bcnt < 100) begin
            bcnt++;
            load = bcnt == 3;
            value = 32'd5;
            @(negedge fnd_clk);
        end
        load = 1'b0;
        n_chk++; if (bcnt !== 33) begin n_fail++; $display("FAIL ign_busy_len got %0d want 33", bcnt); end
        repeat (3) @(negedge fnd_clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue got %b want 0", busy); end
        capture_frame();
        n_chk++; if (frame !== 48'h000000000007) begin n_fail++; $display("FAIL ign_glyphs got %h want 000000000007", frame); end
    endtask

`ifdef FND_BLINK_EN
    task automatic test_blink();
        logic [7:0] want;
        rst = 1'b0;
        blink_mask = 6'b000001;
        repeat (2) @(negedge fnd_clk);
        rst = 1'b1;
        for (int j = 1; j < 146; j++) begin
            @(negedge fnd_clk);
            if (j % 24 == 1) begin
                want = (j / 24 == 2 || j / 24 == 3) ? 8'h00 : 8'h40;
                n_chk++;
                if (fnd_s !== 6'h3E || fnd_d !== want) begin
                    n_fail++; $display("FAIL blink_f%0d got s=%b d=%h want s=111110 d=%h", j / 24, fnd_s, fnd_d, want);
                end
            end
        end
        blink_mask = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_decimal();
        test_hex();
        test_reset_mid();
        test_busy_ignore();
`ifdef FND_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Parametrised multiplexed seven-segment driver that replaces the fixed 6-digit decimal driver in the display path. It accepts a value through a load/busy handshake and converts it sequentially: signed decimal by iterative double-dabble, hexadecimal nibble by nibble. The result is committed atomically to a glyph buffer, which is scanned onto a DIGITS-wide common-select bus at a programmable refresh rate. The block sits between the calculator datapath and the board FND pins.

## Interface
- DIGITS, 6, number of display positions (2..8).
- DATA_W, 32, input value width (8..32).
- SCAN_DIV, 1000, fnd_clk cycles per digit slot (>= 2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (only with FND_BLINK_EN).
- fnd_clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- load  in  1  request; accepted on any cycle with busy=0.
- mode  in  1  0 = signed decimal, 1 = unsigned hex; sampled with load.
- value  in  DATA_W  value to display; sampled with load.
- busy  out  1  conversion in progress.
- overflow  out  1  last committed value did not fit; updated at commit.
- fnd_s  out  DIGITS  digit select, active-low, one-hot-low.
- fnd_d  out  8  segment anodes: bit0=a … bit6=g, bit7=dp (always 0).
- blink_mask  in  DIGITS  per-digit blink enable (only with FND_BLINK_EN).

## Operation
- Reset values (rst=0 at a rising edge):
  - Glyph buffer: all 0x40 ("-").
  - Outputs: busy=0, overflow=0, fnd_s all ones, fnd_d=0x00.
  - Internal state: scan index 0, prescaler 0.
- FSM states and transitions:
  - IDLE: load with busy=0 captures mode and value, then goes to CONV_DEC (mode 0) or CONV_HEX (mode 1). load while busy=1 is ignored, with no queueing.
  - CONV_DEC: magnitude = two's-complement absolute value, taken as unsigned DATA_W so -2^(DATA_W-1) is valid. Double-dabble runs one bit per cycle for DATA_W cycles into an internal BCD register of 4*ceil(DATA_W/3) bits.
  - CONV_HEX: one nibble per cycle for DIGITS cycles. Any nonzero nibble above position DIGITS-1 sets the overflow condition.
  - COMMIT: one cycle. Encodes all glyphs, writes the whole buffer at once, updates overflow, returns to IDLE.
- Glyph rules:
  - Leading zeros are blanked (0x00). Value 0 shows "0" in digit 0 only.
  - Negative decimal: 0x40 goes in the position immediately left of the most significant nonzero digit.
  - Decimal digits: 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x67.
  - Hex letters: A 0x77, b 0x7C, C 0x39, d 0x5E, E 0x79, F 0x71.
- Overflow conditions:
  - A nonzero BCD digit at position >= DIGITS.
  - A negative value whose magnitude occupies all DIGITS positions, leaving no room for the sign.
  - The hex nibble case above.
  - On overflow the buffer shows "Err" right-justified: digit2=0x79, digit1=0x50, digit0=0x50, the rest 0x00. overflow=1.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At wrap, the scan index advances 0..DIGITS-1, then wraps to 0.
  - fnd_s = ~(1<<index) and fnd_d = buffer[index], both registered.
  - Ghost blanking: in prescaler cycle 0 of every slot, fnd_s is all ones.
- The buffer is never partially updated. Scanning continues unchanged during conversion.

## Timing
- Load accepted at edge N. busy=1 from edge N+1.
- Decimal: busy high for DATA_W+1 cycles. Hex: busy high for DIGITS+1 cycles.
- The buffer and overflow change at the edge where busy falls. A new load is accepted in that same cycle only if busy already reads 0, i.e. the next cycle.
- A commit takes effect on fnd_d at the next prescaler tick within the current slot's registered output, at most 1 cycle later.
- Full frame = DIGITS*SCAN_DIV cycles.
- Reset mid-conversion: the conversion is aborted and the reset values apply. Reset has priority over load in the same cycle.

## Configuration
- FND_BLINK_EN defined:
  - Adds the blink_mask port and a frame counter.
  - A blink phase toggles every BLINK_FRAMES completed frames.
  - During the off phase, digits with blink_mask[i]=1 drive fnd_d=0x00; fnd_s still scans.
  - Reset sets the phase to on.
- FND_BLINK_EN undefined: no port, no counter, all digits always lit.

## Test plan
All scenarios use DIGITS=6, DATA_W=32, SCAN_DIV=4.
- Reset held 3 cycles then released → each slot shows fnd_d=0x40; fnd_s sequence 111111 (blank), 111110 ×3, 111111, 111101 ×3 …; busy=0.
- load value=123 mode=0 → busy high 33 cycles; buffer 00,00,00,06,5B,4F (digit5..0); overflow=0.
- load -45 → digit2=0x40, digit1=0x66, digit0=0x6D. Then load -2147483648 → "Err", overflow=1. Then load 999999 → six digits 0x67, overflow=0.
- load 0x0000BEEF mode=1 → busy 7 cycles; digits3..0 = 7C,79,79,71, digits5..4 = 00. Then load 0x01000000 mode=1 → "Err".
- load 7, then pulse load 5 while busy=1 → 5 is ignored, 7 is displayed. rst low at cycle 10 of a conversion → buffer all 0x40, busy=0.
- FND_BLINK_EN with BLINK_FRAMES=2, blink_mask=000001 → digit0 is 0x00 during frames 2–3, lit during frames 0–1 and 4–5.
